// File: rtl/spi_calc_sequencer.sv
// Sequencer for the SPI calculator: handshake, operand/opcode capture, ALU launch and reply.
// Define SPI_SEQ_CHECKSUM_EN to require an XOR checksum byte after the opcode.
module spi_calc_sequencer #(
    parameter logic [7:0]  HS_BYTE  = 8'hAA,
    parameter logic [7:0]  ACK_BYTE = 8'hBB,
    parameter logic [7:0]  NAK_BYTE = 8'hEE,
    parameter int unsigned ALU_LAT  = 1,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       CS,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic       tx_load,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [1:0] operacion,
    output logic       alu_start,
    input  logic [3:0] resultado,
    output logic       LED_handshake,
    output logic       busy,
    output logic       err
);
    // One counter serves the inter-byte timeout, the ALU wait and the two SEND phases.
    localparam int unsigned CntMax = (TIMEOUT > 16) ? TIMEOUT : 16;
    localparam int unsigned CntW   = $clog2(CntMax);

    typedef enum logic [2:0] {
        StIdle, StWaitHs, StGetN1, StGetN2, StGetOp, StGetCk, StExec, StSend
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_load_q, tx_load_d;
    logic [3:0]        num1_q, num1_d, num2_q, num2_d;
    logic [1:0]        op_q, op_d;
    logic              alu_start_q, alu_start_d;
    logic              led_q, led_d;
    logic              err_q, err_d;
    logic              accept, in_get, timed_out;
    logic              get_byte, abort, nak;

    assign accept    = rx_valid && !CS;
    assign in_get    = state_q inside {StGetN1, StGetN2, StGetOp, StGetCk};
    assign timed_out = (cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_byte_d   = tx_byte_q;
        tx_load_d   = 1'b0;
        num1_d      = num1_q;
        num2_d      = num2_q;
        op_d        = op_q;
        alu_start_d = 1'b0;
        led_d       = led_q;
        err_d       = err_q;
        get_byte    = 1'b0;
        abort       = 1'b0;
        nak         = 1'b0;

        // Inside a transaction: CS drop beats timeout, timeout beats an incoming byte.
        if (in_get) begin
            if (CS) begin
                abort = 1'b1;
            end else if (timed_out) begin
                nak = 1'b1;
            end else if (accept) begin
                get_byte = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (!CS) state_d = StWaitHs;
            end
            StWaitHs: begin
                if (CS) begin
                    state_d = StIdle;
                end else if (accept && rx_byte == HS_BYTE) begin
                    state_d   = StGetN1;
                    err_d     = 1'b0;
                    led_d     = 1'b1;
                    tx_byte_d = ACK_BYTE;
                    tx_load_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            StGetN1: begin
                if (get_byte) begin
                    if (|rx_byte[7:4]) begin
                        nak = 1'b1;
                    end else begin
                        num1_d  = rx_byte[3:0];
                        state_d = StGetN2;
                    end
                end
            end
            StGetN2: begin
                if (get_byte) begin
                    if (|rx_byte[7:4]) begin
                        nak = 1'b1;
                    end else begin
                        num2_d  = rx_byte[3:0];
                        state_d = StGetOp;
                    end
                end
            end
            StGetOp: begin
                if (get_byte) begin
                    if (|rx_byte[7:2]) begin
                        nak = 1'b1;
                    end else begin
                        op_d = rx_byte[1:0];
`ifdef SPI_SEQ_CHECKSUM_EN
                        state_d = StGetCk;
`else
                        state_d     = StExec;
                        alu_start_d = 1'b1;
                        cnt_d       = '0;
`endif
                    end
                end
            end
`ifdef SPI_SEQ_CHECKSUM_EN
            StGetCk: begin
                if (get_byte) begin
                    if (rx_byte == ({4'h0, num1_q} ^ {4'h0, num2_q} ^ {6'h0, op_q})) begin
                        state_d     = StExec;
                        alu_start_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        nak = 1'b1;
                    end
                end
            end
`endif
            StExec: begin
                if (cnt_q == CntW'(ALU_LAT - 1)) begin
                    state_d = StSend;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSend: begin
                // First cycle captures the result; second keeps busy high while tx_load shows.
                if (cnt_q == '0) begin
                    tx_byte_d = {4'h0, resultado};
                    tx_load_d = 1'b1;
                    cnt_d     = CntW'(1);
                end else begin
                    state_d = StIdle;
                    led_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort || nak) begin
            state_d = StIdle;
            err_d   = 1'b1;
            led_d   = 1'b0;
            cnt_d   = '0;
        end
        if (nak) begin
            tx_byte_d = NAK_BYTE;
            tx_load_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            tx_byte_q   <= 8'h00;
            tx_load_q   <= 1'b0;
            num1_q      <= 4'h0;
            num2_q      <= 4'h0;
            op_q        <= 2'h0;
            alu_start_q <= 1'b0;
            led_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_byte_q   <= tx_byte_d;
            tx_load_q   <= tx_load_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            op_q        <= op_d;
            alu_start_q <= alu_start_d;
            led_q       <= led_d;
            err_q       <= err_d;
        end
    end

    assign tx_byte       = tx_byte_q;
    assign tx_load       = tx_load_q;
    assign num1          = num1_q;
    assign num2          = num2_q;
    assign operacion     = op_q;
    assign alu_start     = alu_start_q;
    assign LED_handshake = led_q;
    assign busy          = (state_q != StIdle);
    assign err           = err_q;

endmodule

// File: tb/tb_spi_calc_sequencer.sv
// Scoreboard bench for spi_calc_sequencer: transaction-level model predicts replies and ALU
// launches; a monitor compares them as the DUT presents them.
module tb_spi_calc_sequencer;
    localparam int unsigned ALU_LAT = 2;
    localparam int unsigned TIMEOUT = 8;
    localparam logic [7:0]  HS  = 8'hAA;
    localparam logic [7:0]  ACK = 8'hBB;
    localparam logic [7:0]  NAK = 8'hEE;
`ifdef SPI_SEQ_CHECKSUM_EN
    localparam int NF = 5;
`else
    localparam int NF = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       CS = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [3:0] resultado = 4'h0;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [3:0] num1, num2;
    logic [1:0] operacion;
    logic       alu_start, LED_handshake, busy, err;

    spi_calc_sequencer #(
        .ALU_LAT(ALU_LAT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .CS           (CS),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .tx_byte      (tx_byte),
        .tx_load      (tx_load),
        .num1         (num1),
        .num2         (num2),
        .operacion    (operacion),
        .alu_start    (alu_start),
        .resultado    (resultado),
        .LED_handshake(LED_handshake),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [9:0] val;
        int         cyc;
    } exp_t;

    exp_t       tx_q[$];
    exp_t       alu_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] f[5];
    logic [3:0] m_n1 = 4'h0, m_n2 = 4'h0;
    logic [1:0] m_op = 2'h0;
    logic       m_err = 1'b0;
    logic [3:0] alu_res = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_tx(input logic [7:0] v, input int c);
        exp_t e;
        e.val = {2'b00, v};
        e.cyc = c;
        tx_q.push_back(e);
    endtask

    task automatic push_alu(input logic [9:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        alu_q.push_back(e);
    endtask

    // Monitor: every tx_load / alu_start must match the oldest outstanding prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_load) begin
                if (tx_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_unexpected: got tx_byte %0h, expected no tx_load", tx_byte);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_byte", {24'h0, tx_byte}, {22'h0, e.val});
                    check("tx_cycle", cyc, e.cyc);
                end
            end
            if (alu_start) begin
                if (alu_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL alu_unexpected: got alu_start, expected none");
                end else begin
                    e = alu_q.pop_front();
                    check("alu_operands", {22'h0, num1, num2, operacion}, {22'h0, e.val});
                    check("alu_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // ALU stand-in: result is valid only in the cycle the sequencer must sample it.
    initial begin
        forever begin
            @(negedge clk);
            if (alu_start) begin
                repeat (ALU_LAT) @(negedge clk);
                resultado = alu_res;
                @(negedge clk);
                resultado = ~alu_res;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_fields(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o);
        f[0] = HS;
        f[1] = {4'h0, a};
        f[2] = {4'h0, b};
        f[3] = {6'h00, o};
        f[4] = f[1] ^ f[2] ^ f[3];
    endtask

    task automatic apply_model(input int i);
        case (i)
            0: m_err = 1'b0;
            1: m_n1 = f[1][3:0];
            2: m_n2 = f[2][3:0];
            3: m_op = f[3][1:0];
            default: ;
        endcase
    endtask

    // Called at a negedge; byte is presented gap+1 negedges later for one cycle.
    task automatic drive_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
    endtask

    task automatic send_valid(input int k, output int c_last);
        int gap, c;
        c_last = 0;
        for (int i = 0; i < k; i++) begin
            gap = $urandom_range(0, 3);
            c   = cyc + gap + 1;
            if (i == 0) push_tx(ACK, c + 1);
            drive_byte(f[i], gap);
            apply_model(i);
            c_last = c;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        CS       = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("err", {31'h0, err}, {31'h0, m_err});
        check("busy_idle", {31'h0, busy}, 32'h0);
        check("led_idle", {31'h0, LED_handshake}, 32'h0);
        check("num1", {28'h0, num1}, {28'h0, m_n1});
        check("num2", {28'h0, num2}, {28'h0, m_n2});
        check("operacion", {30'h0, operacion}, {30'h0, m_op});
        @(negedge clk);
        CS = 1'b0;
    endtask

    task automatic good_txn(input bit junk_first, input bit cs_exec);
        int cl, gap, c;
        logic [7:0] j;
        if (junk_first) begin
            j = 8'($urandom);
            if (j == HS) j = 8'h55;
            drive_byte(j, $urandom_range(0, 2));
        end
        send_valid(NF - 1, cl);
        gap = $urandom_range(0, 3);
        c   = cyc + gap + 1;
        push_alu({f[1][3:0], f[2][3:0], f[3][1:0]}, c + 1);
        push_tx({4'h0, alu_res}, c + 2 + ALU_LAT);
        drive_byte(f[NF-1], gap);
        apply_model(NF - 1);
        // Bytes arriving during EXEC are ignored; CS high there must not abort.
        rx_valid = 1'b1;
        rx_byte  = HS;
        if (cs_exec) CS = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (ALU_LAT) @(negedge clk);
        check("busy_send", {31'h0, busy}, 32'h1);
        check("led_send", {31'h0, LED_handshake}, 32'h1);
        @(negedge clk);
        check("busy_done", {31'h0, busy}, 32'h0);
        check("led_done", {31'h0, LED_handshake}, 32'h0);
        settle();
    endtask

    task automatic bad_txn(input int p, input logic [7:0] bad);
        int cl, gap, c;
        send_valid(p, cl);
        gap = $urandom_range(0, 3);
        c   = cyc + gap + 1;
        push_tx(NAK, c + 1);
        drive_byte(bad, gap);
        m_err = 1'b1;
        settle();
    endtask

    function automatic logic [7:0] bad_byte(input int p);
        if (p <= 2) return {4'($urandom_range(1, 15)), 4'($urandom)};
        if (p == 3) return {6'($urandom_range(1, 63)), 2'($urandom)};
        return f[4] ^ 8'($urandom_range(1, 255));
    endfunction

    task automatic abort_txn(input int k, input bit drop);
        int cl;
        send_valid(k, cl);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        CS = 1'b1;
        if (drop) begin
            rx_valid = 1'b1;
            rx_byte  = {4'h0, 4'($urandom)};
        end
        m_err = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        settle();
    endtask

    task automatic timeout_txn(input int k);
        int cl;
        send_valid(k, cl);
        push_tx(NAK, cl + TIMEOUT + 1);
        repeat (TIMEOUT + 3) @(negedge clk);
        m_err = 1'b1;
        settle();
    endtask

    initial begin
        int cl, sel;
        repeat (3) @(negedge clk);
        check("rst_tx_byte", {24'h0, tx_byte}, 32'h0);
        check("rst_tx_load", {31'h0, tx_load}, 32'h0);
        check("rst_nums", {22'h0, num1, num2, operacion}, 32'h0);
        check("rst_alu_start", {31'h0, alu_start}, 32'h0);
        check("rst_flags", {29'h0, LED_handshake, busy, err}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        CS = 1'b0;

        set_fields(4'h3, 4'h5, 2'h1);
        alu_res = 4'h8;
        good_txn(1'b0, 1'b0);
        set_fields(4'h9, 4'hC, 2'h2);
        alu_res = 4'h1;
        good_txn(1'b1, 1'b0);
        bad_txn(1, 8'h13);
        set_fields(4'h7, 4'h2, 2'h3);
        good_txn(1'b0, 1'b1);
        abort_txn(2, 1'b0);
        // CS rising with rx_valid in WAIT_HS: the handshake is dropped, no ACK.
        @(negedge clk);
        CS       = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = HS;
        @(negedge clk);
        rx_valid = 1'b0;
        settle();
        set_fields(4'hE, 4'h4, 2'h0);
        abort_txn(2, 1'b1);
        timeout_txn(1);
`ifdef SPI_SEQ_CHECKSUM_EN
        set_fields(4'h3, 4'h5, 2'h1);
        bad_txn(4, 8'h06);
`endif
        set_fields(4'hB, 4'h6, 2'h1);
        send_valid(2, cl);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx_load", {31'h0, tx_load}, 32'h0);
        check("midrst_tx_byte", {24'h0, tx_byte}, 32'h0);
        check("midrst_num1", {28'h0, num1}, 32'h0);
        check("midrst_flags", {29'h0, LED_handshake, busy, err}, 32'h0);
        rst  = 1'b0;
        m_n1 = 4'h0;
        m_n2 = 4'h0;
        m_op = 2'h0;
        m_err = 1'b0;
        settle();

        for (int n = 0; n < 60; n++) begin
            set_fields(4'($urandom), 4'($urandom), 2'($urandom));
            alu_res = 4'($urandom);
            sel = $urandom_range(0, 4);
            case (sel)
                0, 1: good_txn(1'($urandom), 1'($urandom));
                2: begin
                    int p;
                    p = $urandom_range(1, NF - 1);
                    bad_txn(p, bad_byte(p));
                end
                3: abort_txn($urandom_range(1, NF - 1), 1'($urandom));
                default: timeout_txn($urandom_range(1, NF - 1));
            endcase
        end

        repeat (TIMEOUT + 4) @(negedge clk);
        check("tx_q_drained", tx_q.size(), 32'h0);
        check("alu_q_drained", alu_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
